serial_link_obi_arbiter: RTL
============================

Name: serial_link_obi_arbiter

Overview:
- Shares the single OBI slave port of the serial-link TX path (OBI-to-AXI-Lite bridge) between NumReq OBI masters, e.g. core data port and DMA.
- Sits directly in front of the serial-link wrapper's OBI input.
- Arbitrates round-robin and holds the winner stable until the downstream grant.
- Tracks outstanding transactions in an in-order ID FIFO so each rvalid/rdata returns to the master that issued the request.

Parameters:
- NumReq, 2, number of upstream OBI masters (>=2).
- AddrWidth, 32, OBI address width.
- DataWidth, 32, OBI data width; byte-enable width is DataWidth/8.
- MaxOutstanding, 4, maximum granted-but-unanswered transactions (>=1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  NumReq  per-master request.
- addr_i  in  NumReq x AddrWidth  per-master address.
- we_i  in  NumReq  per-master write enable.
- be_i  in  NumReq x DataWidth/8  per-master byte enable.
- wdata_i  in  NumReq x DataWidth  per-master write data.
- gnt_o  out  NumReq  per-master grant.
- rvalid_o  out  NumReq  per-master response valid.
- rdata_o  out  DataWidth  response data, broadcast to all masters.
- mst_req_o  out  1  downstream request.
- mst_addr_o  out  AddrWidth  downstream address.
- mst_we_o  out  1  downstream write enable.
- mst_be_o  out  DataWidth/8  downstream byte enable.
- mst_wdata_o  out  DataWidth  downstream write data.
- mst_gnt_i  in  1  downstream grant.
- mst_rvalid_i  in  1  downstream response valid.
- mst_rdata_i  in  DataWidth  downstream response data.
- outstanding_o  out  $clog2(MaxOutstanding+1)  current outstanding count.
- err_o  out  1  sticky error: mst_rvalid_i received with no outstanding transaction.

Behaviour:
- Reset (async, rst_ni=0):
  - Round-robin pointer = 0, lock clear, ID FIFO empty, count = 0, err_o = 0.
  - All outputs 0 while in reset; rdata_o follows mst_rdata_i.
- States: IDLE (no lock) and LOCKED (request presented, not yet granted), held in a lock flag plus a lock index register.
- IDLE:
  - Winner = first index with req_i=1, searching from the pointer upward with wrap (pointer, pointer+1, ..., NumReq-1, 0, ...).
  - If no req_i is set, mst_req_o=0.
- Downstream request:
  - mst_req_o = req_i[sel] AND NOT fifo_full.
  - mst_addr/we/be/wdata come from master sel.
  - sel = lock index when LOCKED, otherwise the IDLE winner.
- Transition to LOCKED: mst_req_o=1 and mst_gnt_i=0 → register sel into the lock index. The master, and therefore the payload, cannot change until grant.
- Handshake (mst_req_o & mst_gnt_i):
  - gnt_o[sel]=1 in the same cycle (combinational pass-through); all other gnt_o bits are 0.
  - Push sel into the ID FIFO.
  - Pointer = sel+1 mod NumReq.
  - Return to IDLE.
- Lock abandonment: if req_i[lock index] drops while LOCKED (protocol violation), the lock is released next cycle and the pointer is unchanged.
- FIFO full (count == MaxOutstanding):
  - mst_req_o forced to 0 and no grants are issued, even if mst_rvalid_i pops in the same cycle. Full means stall, which keeps the path free of combinational loops.
  - Lock state is retained.
- Response path:
  - OBI responses are in order.
  - mst_rvalid_i=1 with FIFO non-empty → rvalid_o[fifo head]=1 in the same cycle, then pop.
  - rdata_o = mst_rdata_i always.
- Simultaneous push and pop (allowed when not full): count unchanged, head advances.
- mst_rvalid_i with FIFO empty: no rvalid_o, err_o set to 1 and held until reset.
- A response may arrive no earlier than one cycle after its grant. A same-cycle grant-and-rvalid for the same transaction is not supported.
- Count width is $clog2(MaxOutstanding+1). The FIFO pointers wrap modulo MaxOutstanding.

Decomposition:
- No new package; all widths derive from parameters. ID width is $clog2(NumReq), minimum 1.
- Sub-module serial_link_arb_id_fifo:
  - Synchronous FIFO, DEPTH=MaxOutstanding, data width = ID width.
  - Outputs full, empty, head, count.
  - Same clock and reset as the parent.
- The top-level holds the round-robin pointer, lock FSM, payload muxes and error flag.

Test Plan:
- Single master, immediate grant: req_i=01, addr_i[0]=0x1000, we=1, wdata=0xDEADBEEF, mst_gnt_i=1 → same cycle mst_addr_o=0x1000, gnt_o=01; rvalid 2 cycles later → rvalid_o=01, outstanding_o back to 0.
- Fairness: req_i=11 held, mst_gnt_i=1 every cycle → grants alternate 01,10,01,10 starting at 01 after reset.
- Grant backpressure: req_i=11, mst_gnt_i=0 for 3 cycles, master 0 selected → mst_addr_o stays master 0's value all 3 cycles; on grant gnt_o=01, and the next selection is master 1.
- Outstanding limit: MaxOutstanding=4, no rvalid, continuous requests → 4 grants, then mst_req_o=0 and outstanding_o=4; one rvalid → count 3, next cycle a grant resumes.
- Response routing: grant order m1,m0,m1, then three rvalids with rdata 0xA,0xB,0xC → rvalid_o=10,01,10 with rdata_o 0xA,0xB,0xC.
- Error and reset: mst_rvalid_i=1 when empty → err_o=1 and sticky; assert rst_ni=0 mid-burst with 2 outstanding → outputs 0, outstanding_o=0, err_o=0, pointer 0.

Source files
------------

// File: rtl/serial_link_arb_id_fifo.sv
// In-order ID FIFO for the serial-link OBI arbiter.
// Remembers which upstream master owns each granted-but-unanswered
// transaction so responses can be routed back in issue order.
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   push_i, data_i enqueue an ID (ignored when full)
//   pop_i          dequeue the head ID (ignored when empty)
//   head_o         ID at the head of the queue
//   full_o, empty_o, count_o  occupancy status
module serial_link_arb_id_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CntW  = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  rd_ptr, wr_ptr;
    logic [CntW-1:0]  count;
    logic             do_push, do_pop;

    // Pointers wrap modulo DEPTH, so non-power-of-two depths work too.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (count == CntW'(DEPTH));
    assign empty_o = (count == '0);
    assign count_o = count;
    assign head_o  = mem[rd_ptr];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/serial_link_obi_arbiter.sv
// Round-robin OBI arbiter in front of the serial-link TX OBI port.
// Shares one downstream OBI slave between NumReq masters, holds the
// selected master stable until the downstream grant, and routes in-order
// responses back to the issuing master through an ID FIFO.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_i/addr_i/we_i/be_i/wdata_i  per-master OBI request channel
//   gnt_o, rvalid_o               per-master grant / response valid
//   rdata_o                       response data, broadcast to all masters
//   mst_*                         downstream OBI master port
//   outstanding_o                 granted-but-unanswered transaction count
//   err_o                         sticky: response seen with nothing outstanding
module serial_link_obi_arbiter #(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumReq-1:0]                   req_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]    addr_i,
    input  logic [NumReq-1:0]                   we_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0]  be_i,
    input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
    output logic [NumReq-1:0]                   gnt_o,
    output logic [NumReq-1:0]                   rvalid_o,
    output logic [DataWidth-1:0]                rdata_o,
    output logic                                mst_req_o,
    output logic [AddrWidth-1:0]                mst_addr_o,
    output logic                                mst_we_o,
    output logic [DataWidth/8-1:0]              mst_be_o,
    output logic [DataWidth-1:0]                mst_wdata_o,
    input  logic                                mst_gnt_i,
    input  logic                                mst_rvalid_i,
    input  logic [DataWidth-1:0]                mst_rdata_i,
    output logic [CntW-1:0]                     outstanding_o,
    output logic                                err_o
);

    localparam int unsigned IdW = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e          state;
    logic [IdW-1:0]  lock_idx;
    logic [IdW-1:0]  rr_ptr;
    logic [IdW-1:0]  winner, sel, head;
    logic            fifo_full, fifo_empty;
    logic            hs, pop;

    // Rotating priority search: first requester at or above rr_ptr, wrapping.
    always_comb begin
        int  k;
        logic found;
        winner = '0;
        found  = 1'b0;
        k      = 0;
        for (int i = 0; i < int'(NumReq); i++) begin
            k = int'(rr_ptr) + i;
            if (k >= int'(NumReq)) k = k - int'(NumReq);
            if (!found && req_i[k]) begin
                found  = 1'b1;
                winner = IdW'(k);
            end
        end
    end

    assign sel = (state == LOCKED) ? lock_idx : winner;

    // A full FIFO stalls new requests outright, even when a response pops
    // in the same cycle; that keeps rvalid off the grant path.
    assign mst_req_o   = rst_ni & req_i[sel] & ~fifo_full;
    assign mst_addr_o  = rst_ni ? addr_i[sel]  : '0;
    assign mst_we_o    = rst_ni & we_i[sel];
    assign mst_be_o    = rst_ni ? be_i[sel]    : '0;
    assign mst_wdata_o = rst_ni ? wdata_i[sel] : '0;
    assign rdata_o     = mst_rdata_i;

    assign hs  = mst_req_o & mst_gnt_i;
    assign pop = rst_ni & mst_rvalid_i & ~fifo_empty;

    always_comb begin
        gnt_o         = '0;
        gnt_o[sel]    = hs;
        rvalid_o      = '0;
        rvalid_o[head] = pop;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            lock_idx <= '0;
            rr_ptr   <= '0;
        end else begin
            if (hs) begin
                state  <= IDLE;
                rr_ptr <= (sel == IdW'(NumReq - 1)) ? '0 : sel + IdW'(1);
            end else if (state == LOCKED && !req_i[lock_idx]) begin
                // Master withdrew its request: drop the lock, keep priority.
                state <= IDLE;
            end else if (mst_req_o) begin
                state    <= LOCKED;
                lock_idx <= sel;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_o <= 1'b0;
        else if (mst_rvalid_i && fifo_empty) err_o <= 1'b1;
    end

    serial_link_arb_id_fifo #(
        .DEPTH (MaxOutstanding),
        .WIDTH (IdW),
        .CntW  (CntW)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (hs),
        .pop_i   (pop),
        .data_i  (sel),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_o)
    );

endmodule
